// File: rtl/uart_tx_if.sv
// Transmit-side handshake bundle for uart_tx: byte/baud request in, serial line and status out.
`timescale 1ns/1ps
interface uart_tx_if;
  logic [3:0] baud_set;
  logic       send_en;
  logic [7:0] data_byte;
  logic       tx;
  logic       busy;
  logic       tx_done;

  modport master (
    output baud_set, send_en, data_byte,
    input  tx, busy, tx_done
  );

  modport slave (
    input  baud_set, send_en, data_byte,
    output tx, busy, tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter (8N1, LSB first) with an integrated 1x bit-rate divider.
// Optional even parity bit between d7 and stop when UART_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_tx #(
  parameter int SYSTEM_CLK = 50_000_000,
  parameter int DIV_W      = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(SYSTEM_CLK / 9600   - 1);
  localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'(SYSTEM_CLK / 19200  - 1);
  localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(SYSTEM_CLK / 38400  - 1);
  localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'(SYSTEM_CLK / 57600  - 1);
  localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(SYSTEM_CLK / 115200 - 1);
  localparam logic [DIV_W-1:0] DIV_230400 = DIV_W'(SYSTEM_CLK / 230400 - 1);
  localparam logic [DIV_W-1:0] DIV_460800 = DIV_W'(SYSTEM_CLK / 460800 - 1);
  localparam logic [DIV_W-1:0] DIV_921600 = DIV_W'(SYSTEM_CLK / 921600 - 1);

`ifdef UART_PARITY_EN
  localparam logic [3:0] LAST_BIT   = 4'd10;
  localparam logic [3:0] PARITY_BIT = 4'd9;
`else
  localparam logic [3:0] LAST_BIT   = 4'd9;
`endif

  function automatic logic [DIV_W-1:0] div_sel(input logic [3:0] sel);
    logic [DIV_W-1:0] d;
    case (sel)
      4'd0:    d = DIV_9600;
      4'd1:    d = DIV_19200;
      4'd2:    d = DIV_38400;
      4'd3:    d = DIV_57600;
      4'd4:    d = DIV_115200;
      4'd5:    d = DIV_230400;
      4'd6:    d = DIV_460800;
      4'd7:    d = DIV_921600;
      default: d = DIV_9600;
    endcase
    return d;
  endfunction

`ifdef UART_PARITY_EN
  function automatic logic parity_even(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_div_cnt;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_busy;
  logic             r_tx_done;
`ifdef UART_PARITY_EN
  logic             r_parity;
`endif

  logic [3:0]       w_bit_nxt;
  logic             w_tx_nxt;

  // Line level for the bit about to start; data comes from the LSB of the shift register.
  always_comb begin
    w_bit_nxt = r_bit_cnt + 4'd1;
    w_tx_nxt  = 1'b1;
    if (w_bit_nxt <= 4'd8) begin
      w_tx_nxt = r_shift[0];
`ifdef UART_PARITY_EN
    end else if (w_bit_nxt == PARITY_BIT) begin
      w_tx_nxt = r_parity;
`endif
    end else begin
      w_tx_nxt = 1'b1;
    end
  end

  // Frame FSM: acceptance latches divisor/data, divider paces bits, stop bit ends in a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_div_cnt <= '0;
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
`ifdef UART_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.send_en) begin
            r_state   <= S_SEND;
            r_div     <= div_sel(bus.baud_set);
            r_div_cnt <= '0;
            r_bit_cnt <= 4'd0;
            r_shift   <= bus.data_byte;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
`ifdef UART_PARITY_EN
            r_parity  <= parity_even(bus.data_byte);
`endif
          end else begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        S_SEND: begin
          if (r_div_cnt == r_div) begin
            r_div_cnt <= '0;
            if (r_bit_cnt == LAST_BIT) begin
              // Stop bit finished: the done cycle doubles as the one idle-high gap.
              r_state   <= S_IDLE;
              r_bit_cnt <= 4'd0;
              r_tx      <= 1'b1;
              r_busy    <= 1'b0;
              r_tx_done <= 1'b1;
            end else begin
              r_bit_cnt <= w_bit_nxt;
              r_tx      <= w_tx_nxt;
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1'b1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx      = r_tx;
  assign bus.busy    = r_busy;
  assign bus.tx_done = r_tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line monitor decodes and checks them.
`timescale 1ns/1ps
module tb_uart_tx;

`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct {
    logic [7:0] data;
    int         w;
    bit         abort;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q[$];
  int   done_cyc[$];
  int   done_cnt = 0;
  bit   mon_busy = 1'b0;

  uart_tx_if bus ();

  uart_tx #(.SYSTEM_CLK(50_000_000), .DIV_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Bit period in clocks (DIV+1) for a 50 MHz clock, computed by hand.
  function automatic int w_for(input logic [3:0] b);
    case (b)
      4'd0:    return 5208;
      4'd1:    return 2604;
      4'd2:    return 1302;
      4'd3:    return 868;
      4'd4:    return 434;
      4'd5:    return 217;
      4'd6:    return 108;
      4'd7:    return 54;
      default: return 5208;
    endcase
  endfunction

  function automatic logic exp_bit(input logic [7:0] d, input int k);
    logic [7:0] t;
    if (k == 0) return 1'b0;
    if (k <= 8) begin
      t = d >> (k - 1);
      return t[0];
    end
    if (NB == 11 && k == 9) return ^d;
    return 1'b1;
  endfunction

  // Line monitor: decodes each frame, pops the expected entry and compares.
  initial begin : monitor
    exp_t       e;
    logic [7:0] got;
    int         berr;
    int         busyerr;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) continue;
      if (bus.tx_done === 1'b1) chk("spurious_done", 32'd1, 32'd0);
      if (bus.tx === 1'b0) begin
        if (bus.busy !== 1'b1) begin
          chk("idle_tx_low_busy", {31'd0, bus.busy}, 32'd1);
          continue;
        end
        mon_busy = 1'b1;
        if (q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
          e = '{data: 8'h00, w: 54, abort: 1'b0};
        end else begin
          e = q.pop_front();
        end
        got = 8'h00; berr = 0; busyerr = 0; aborted = 1'b0;
        for (int k = 0; k < NB * e.w; k++) begin
          if (k > 0) @(negedge clk);
          if (rst !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (bus.tx !== exp_bit(e.data, k / e.w)) berr++;
          if (bus.busy !== 1'b1 || bus.tx_done !== 1'b0) busyerr++;
          if ((k % e.w) == (e.w / 2) && (k / e.w) >= 1 && (k / e.w) <= 8)
            got = {bus.tx, got[7:1]};
        end
        if (aborted) begin
          chk("abort_expected", {31'd0, e.abort}, 32'd1);
          chk("rst_tx",   {31'd0, bus.tx},      32'd1);
          chk("rst_busy", {31'd0, bus.busy},    32'd0);
          chk("rst_done", {31'd0, bus.tx_done}, 32'd0);
        end else begin
          chk("abort_flag", {31'd0, e.abort}, 32'd0);
          chk("data", {24'd0, got}, {24'd0, e.data});
          chk("bit_errs", berr, 32'd0);
          chk("busy_errs", busyerr, 32'd0);
          @(negedge clk);
          chk("done_pulse", {29'd0, bus.tx_done, bus.busy, bus.tx}, 32'd5);
          done_cnt++;
          done_cyc.push_back(cyc);
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [3:0] b, input bit ab);
    int n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    bus.data_byte = d;
    bus.baud_set  = b;
    bus.send_en   = 1'b1;
    q.push_back('{data: d, w: w_for(b), abort: ab});
    @(posedge clk);
    #1 bus.send_en = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((q.size() != 0 || mon_busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'd0, (n >= max)}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0;
    int n0;
    int n;
    rst = 1'b0;
    bus.send_en = 1'b0;
    bus.data_byte = 8'h00;
    bus.baud_set = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_state", {29'd0, bus.tx, bus.busy, bus.tx_done}, 32'd4);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame at 921600.
    send(8'h55, 4'd7, 1'b0);
    wait_drain(2000);
    chk("basic_done_cnt", done_cnt, 32'd1);

    // Slow rate; baud and data change mid-frame must not matter.
    send(8'hA3, 4'd0, 1'b0);
    repeat (3 * 5208) @(posedge clk);
    #1 bus.baud_set = 4'd7;
    bus.data_byte = 8'h5C;
    wait_drain(60000);

    // Request while busy is ignored.
    d0 = done_cnt;
    send(8'h00, 4'd7, 1'b0);
    repeat (100) @(posedge clk);
    #1 bus.send_en = 1'b1;
    bus.data_byte = 8'hFF;
    @(posedge clk);
    #1 bus.send_en = 1'b0;
    wait_drain(2000);
    repeat (20) @(negedge clk);
    chk("ignore_one_done", done_cnt - d0, 32'd1);

    // Back-to-back with send_en held high.
    n0 = done_cyc.size();
    @(negedge clk);
    bus.data_byte = 8'h12;
    bus.baud_set  = 4'd7;
    bus.send_en   = 1'b1;
    q.push_back('{data: 8'h12, w: 54, abort: 1'b0});
    @(posedge clk);
    #1 bus.data_byte = 8'h34;
    q.push_back('{data: 8'h34, w: 54, abort: 1'b0});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tx_done !== 1'b1 && n < 2000);
    chk("b2b_done_seen", {31'd0, bus.tx_done}, 32'd1);
    @(posedge clk);
    #1 bus.send_en = 1'b0;
    wait_drain(2000);
    if (done_cyc.size() >= n0 + 2)
      chk("b2b_spacing", done_cyc[n0 + 1] - done_cyc[n0], 32'd541);
    else
      chk("b2b_frames", done_cyc.size() - n0, 32'd2);

    // Reset during d3 aborts the frame without a done pulse.
    d0 = done_cnt;
    send(8'h96, 4'd7, 1'b1);
    repeat (4 * 54 + 20) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_line", {30'd0, bus.tx, bus.busy}, 32'd2);
    rst = 1'b1;
    repeat (600) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 32'd0);
    send(8'hC6, 4'd7, 1'b0);
    wait_drain(2000);

`ifdef UART_PARITY_EN
    send(8'h07, 4'd7, 1'b0);
    send(8'h55, 4'd7, 1'b0);
    wait_drain(3000);
`endif

    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter with an integrated 1x bit-rate divider. It is the transmit counterpart of the uart receive path and uses the same 4-bit baud_set encoding. It accepts one byte per send_en request and serialises it LSB-first as 8N1: start bit, 8 data bits, stop bit. It reports busy while a frame is in progress and pulses tx_done when the frame ends.

Parameters:
SYSTEM_CLK, 50_000_000, clk frequency in Hz; all bit divisors are derived from it.
DIV_W, 16, width of the bit-period counter; must hold SYSTEM_CLK/9600-1.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-low reset.
baud_set  input  4  baud select; sampled only when a frame is accepted.
send_en  input  1  request to send; acted on only when busy=0.
data_byte  input  8  byte to send; sampled in the same cycle as an accepted send_en.
tx  output  1  serial line; idles high.
busy  output  1  high while a frame is in progress.
tx_done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, busy=0, tx_done=0.
  - state=IDLE; all counters and latches cleared.
  - Reset asserted mid-frame aborts the frame immediately: tx returns high and no tx_done is issued.
- Divisor is DIV=SYSTEM_CLK/baud-1, using integer division. baud_set mapping:
  - 0=9600, 1=19200, 2=38400, 3=57600
  - 4=115200, 5=230400, 6=460800, 7=921600
  - 8..15 select 9600.
- Divisor, data_byte and baud_set are latched at acceptance. Changes to baud_set or data_byte during a frame have no effect.
- States: IDLE, SEND.
  - IDLE -> SEND when send_en=1. busy rises on the next clk edge.
  - SEND -> IDLE after the last bit period completes.
- Frame timing:
  - tx drives the start bit (0) from the edge on which busy rises.
  - Every bit is held exactly DIV+1 clk cycles.
  - bit_cnt runs 0..9: start, d0..d7, stop (1).
  - Frame length is 10*(DIV+1) cycles from the rise of busy.
- End of frame:
  - In the cycle after the stop bit's last clk, tx_done=1 for one cycle and busy=0.
  - tx stays 1.
  - send_en=1 in that same cycle is accepted: back-to-back frames, with tx remaining 1 for exactly that one cycle between stop and the next start.
- send_en while busy=1 is ignored. No queuing, no error flag.
- send_en held high continuously produces back-to-back frames of successive sampled data_byte values.
- tx, busy and tx_done are all registered outputs (no combinational path from inputs).
- bit_cnt and the divider counter both reset to 0 on acceptance. The divider counter wraps DIV->0 on each bit boundary.

Optional Feature:
UART_PARITY_EN:
- Defined: an even-parity bit (XOR of d0..d7) is inserted between d7 and the stop bit. bit_cnt runs 0..10 and the frame is 11*(DIV+1) cycles; tx_done and busy timing shift accordingly.
- Undefined: 8N1 exactly as above, with no parity logic present.

Test Plan:
- Reset: rst=0 mid-frame (baud_set=7, during d3) -> tx=1, busy=0 immediately; no tx_done; after release the next send_en yields a clean frame.
- Basic frame: baud_set=7 (DIV=53), data_byte=0x55, send_en for 1 cycle -> busy high for 540 cycles; tx sequence 0,1,0,1,0,1,0,1,0,1 with 54 cycles per bit; tx_done pulse at cycle 540.
- Slow rate: baud_set=0, data_byte=0xA3 -> 5208 cycles per bit; data bits 1,1,0,0,0,1,0,1; baud_set changed to 7 mid-frame has no effect on bit width.
- Ignore while busy: second send_en with 0xFF during the frame of 0x00 -> only 0x00 transmitted; one tx_done.
- Back-to-back: send_en held high with 0x12 then 0x34 -> two frames separated by exactly one idle-high cycle; two tx_done pulses 541 cycles apart (baud_set=7).
- Parity (UART_PARITY_EN): 0x07 -> parity bit 1; 0x55 -> parity bit 0; frame 594 cycles at baud_set=7.
